// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - field-level instruction encoder that loads 20-bit words into instruction memory
// Optional opcode legality checking is enabled by defining ENC_CHECK_EN.
module instr_encoder #(
  parameter logic [7:0] START_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [4:0]  in_opc,
  input  logic [4:0]  in_dst,
  input  logic [4:0]  in_src1,
  input  logic [4:0]  in_src0,
  input  logic [7:0]  in_imm,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [19:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err_illegal,
  output logic        err_full,
  output logic [8:0]  word_count
);

  // Opcode values shared with def.h
  localparam logic [4:0] OPC_INC    = 5'd0;
  localparam logic [4:0] OPC_DEC    = 5'd1;
  localparam logic [4:0] OPC_MOV    = 5'd2;
  localparam logic [4:0] OPC_RL_90  = 5'd3;
  localparam logic [4:0] OPC_RL_180 = 5'd4;
  localparam logic [4:0] OPC_RL_270 = 5'd5;
  localparam logic [4:0] OPC_UD_90  = 5'd6;
  localparam logic [4:0] OPC_UD_180 = 5'd7;
  localparam logic [4:0] OPC_UD_270 = 5'd8;
  localparam logic [4:0] OPC_FB_90  = 5'd9;
  localparam logic [4:0] OPC_FB_180 = 5'd10;
  localparam logic [4:0] OPC_FB_270 = 5'd11;
  localparam logic [4:0] OPC_LOAD   = 5'd12;
  localparam logic [4:0] OPC_STORE  = 5'd13;
  localparam logic [4:0] OPC_LI     = 5'd14;
  localparam logic [4:0] OPC_CHECK  = 5'd15;
  localparam logic [4:0] OPC_JMP    = 5'd16;
  localparam logic [4:0] OPC_JNZ    = 5'd17;
  localparam logic [4:0] OPC_ZNJ    = 5'd18;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  addr;
  logic [19:0] enc_word;
  logic        enc_legal;
  logic        fire;
  logic        at_end;
  logic        session_start;

  assign in_ready      = (state == S_RUN);
  assign busy          = (state == S_RUN);
  assign done          = (state == S_DONE);
  assign fire          = in_valid & in_ready;
  assign at_end        = (addr == 8'hFF);
  assign session_start = start & (state != S_RUN);

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_opc)
      OPC_INC, OPC_DEC, OPC_MOV,
      OPC_RL_90, OPC_RL_180, OPC_RL_270,
      OPC_UD_90, OPC_UD_180, OPC_UD_270,
      OPC_FB_90, OPC_FB_180, OPC_FB_270:
        enc_word = {in_opc, in_dst, 5'b0, in_src0};
      OPC_LOAD:  enc_word = {in_opc, in_dst, in_src1, 5'b0};
      OPC_STORE: enc_word = {in_opc, 5'b0, in_src1, in_src0};
      OPC_LI:    enc_word = {in_opc, in_dst, in_imm, 2'b00};
      OPC_CHECK: enc_word = {in_opc, in_src1, in_imm, 2'b00};
      OPC_JMP, OPC_JNZ, OPC_ZNJ:
        enc_word = {in_opc, 7'b0, in_imm};
      default: begin
`ifdef ENC_CHECK_EN
        enc_legal = 1'b0;
`else
        enc_word  = {in_opc, in_dst, in_src1, in_src0};
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A write to 8'hFF terminates the session so the address never wraps
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (fire && (in_last || (enc_legal && at_end))) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= START_ADDR;
      imem_we    <= 1'b0;
      imem_addr  <= START_ADDR;
      imem_wdata <= '0;
      word_count <= '0;
      err_full   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (session_start) begin
        addr       <= START_ADDR;
        word_count <= '0;
        err_full   <= 1'b0;
      end else if (fire && enc_legal) begin
        imem_we    <= 1'b1;
        imem_addr  <= addr;
        imem_wdata <= enc_word;
        addr       <= addr + 8'd1;
        word_count <= word_count + 9'd1;
        if (at_end && !in_last) err_full <= 1'b1;
      end
    end
  end

`ifdef ENC_CHECK_EN
  logic err_illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_illegal_q <= 1'b0;
    end else if (session_start) begin
      err_illegal_q <= 1'b0;
    end else if (fire && !enc_legal) begin
      err_illegal_q <= 1'b1;
    end
  end

  assign err_illegal = err_illegal_q;
`else
  assign err_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder
// Honours ENC_CHECK_EN the same way as the design.
module tb_instr_encoder;

  localparam int INC = 0, MOV = 2, LOAD = 12, STORE = 13, LI = 14, CHECK = 15, JMP = 16, JNZ = 17;
  localparam int BAD_OPC = 31;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_last;
  logic [4:0]  in_opc, in_dst, in_src1, in_src0;
  logic [7:0]  in_imm;

  logic        in_ready, imem_we, busy, done, err_illegal, err_full;
  logic [7:0]  imem_addr;
  logic [19:0] imem_wdata;
  logic [8:0]  word_count;

  logic        f_in_ready, f_imem_we, f_busy, f_done, f_err_illegal, f_err_full;
  logic [7:0]  f_imem_addr;
  logic [19:0] f_imem_wdata;
  logic [8:0]  f_word_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_opc(in_opc), .in_dst(in_dst), .in_src1(in_src1),
    .in_src0(in_src0), .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err_illegal(err_illegal),
    .err_full(err_full), .word_count(word_count)
  );

  instr_encoder #(.START_ADDR(8'hFE)) dut_f (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(f_in_ready),
    .in_last(in_last), .in_opc(in_opc), .in_dst(in_dst), .in_src1(in_src1),
    .in_src0(in_src0), .in_imm(in_imm), .imem_we(f_imem_we), .imem_addr(f_imem_addr),
    .imem_wdata(f_imem_wdata), .busy(f_busy), .done(f_done), .err_illegal(f_err_illegal),
    .err_full(f_err_full), .word_count(f_word_count)
  );

  // Instruction word built from the field layout of each opcode class
  function automatic logic [19:0] ref_encode(input int opc, input int dst, input int src1,
                                             input int src0, input int imm, output bit legal);
    int w;
    legal = 1'b1;
    if (opc <= 11)      w = opc * 32768 + dst * 1024 + src0;
    else if (opc == 12) w = opc * 32768 + dst * 1024 + src1 * 32;
    else if (opc == 13) w = opc * 32768 + src1 * 32 + src0;
    else if (opc == 14) w = opc * 32768 + dst * 1024 + imm * 4;
    else if (opc == 15) w = opc * 32768 + src1 * 1024 + imm * 4;
    else if (opc <= 18) w = opc * 32768 + imm;
    else begin
`ifdef ENC_CHECK_EN
      legal = 1'b0;
      w = 0;
`else
      w = opc * 32768 + dst * 1024 + src1 * 32 + src0;
`endif
    end
    return w[19:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    in_opc = '0; in_dst = '0; in_src1 = '0; in_src0 = '0; in_imm = '0;
  endtask

  task automatic drive_beat(input int opc, input int dst, input int src1, input int src0,
                            input int imm, input bit last);
    in_valid = 1'b1; in_last = last;
    in_opc = opc[4:0]; in_dst = dst[4:0]; in_src1 = src1[4:0]; in_src0 = src0[4:0];
    in_imm = imm[7:0];
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset;
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    idle_in();
    rst = 1'b1;
    #7;
    vectors++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, busy, done, err_illegal, err_full, word_count}
        !== {1'b0, 1'b0, 8'h00, 20'h0, 4'b0000, 9'd0}) begin
      miscompares++;
      $display("FAIL reset_main: got rdy=%b we=%b addr=%h wd=%h busy=%b done=%b ill=%b full=%b wc=%0d expected all zero",
               in_ready, imem_we, imem_addr, imem_wdata, busy, done, err_illegal, err_full, word_count);
    end
    vectors++;
    if ({f_in_ready, f_imem_we, f_imem_addr, f_imem_wdata, f_busy, f_done, f_err_full, f_word_count}
        !== {1'b0, 1'b0, 8'hFE, 20'h0, 3'b000, 9'd0}) begin
      miscompares++;
      $display("FAIL reset_start_addr: got addr=%h we=%b wc=%0d expected addr=fe we=0 wc=0",
               f_imem_addr, f_imem_we, f_word_count);
    end
    do_reset();
  endtask

  task automatic test_single_li;
    bit lg;
    logic [19:0] exp;
    do_reset();
    pulse_start();
    vectors++;
    if ({busy, in_ready, done} !== 3'b110) begin
      miscompares++;
      $display("FAIL start_run: got busy=%b rdy=%b done=%b expected 1 1 0", busy, in_ready, done);
    end
    exp = ref_encode(LI, 3, 0, 0, 8'h5A, lg);
    drive_beat(LI, 3, 0, 0, 8'h5A, 1'b1);
    tick();
    idle_in();
    vectors++;
    if ({imem_we, imem_addr, imem_wdata, word_count, done, busy, in_ready}
        !== {1'b1, 8'h00, exp, 9'd1, 3'b100}) begin
      miscompares++;
      $display("FAIL single_li: got we=%b addr=%h wd=%h wc=%0d done=%b busy=%b rdy=%b expected 1 00 %h 1 1 0 0",
               imem_we, imem_addr, imem_wdata, word_count, done, busy, in_ready, exp);
    end
    tick();
    vectors++;
    if ({imem_we, done, word_count} !== {1'b0, 1'b1, 9'd1}) begin
      miscompares++;
      $display("FAIL single_pulse: got we=%b done=%b wc=%0d expected 0 1 1", imem_we, done, word_count);
    end
  endtask

  task automatic test_back_to_back;
    bit lg;
    logic [19:0] exp [3];
    exp[0] = ref_encode(INC, 1, 0, 2, 0, lg);
    exp[1] = ref_encode(STORE, 0, 4, 5, 0, lg);
    exp[2] = ref_encode(JNZ, 0, 0, 0, 8'h10, lg);
    do_reset();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive_beat(INC, 1, 0, 2, 0, 1'b0);
        1: drive_beat(STORE, 0, 4, 5, 0, 1'b0);
        default: drive_beat(JNZ, 0, 0, 0, 8'h10, 1'b1);
      endcase
      tick();
      vectors++;
      if ({imem_we, imem_addr, imem_wdata, word_count, done}
          !== {1'b1, i[7:0], exp[i], 9'(i + 1), (i == 2)}) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got we=%b addr=%h wd=%h wc=%0d done=%b expected 1 %h %h %0d %b",
                 i, imem_we, imem_addr, imem_wdata, word_count, done, i[7:0], exp[i], i + 1, i == 2);
      end
    end
    idle_in();
  endtask

  task automatic test_full;
    bit lg;
    logic [19:0] exp;
    exp = ref_encode(MOV, 7, 0, 9, 0, lg);
    do_reset();
    pulse_start();
    drive_beat(MOV, 7, 0, 9, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (f_in_ready !== (i < 2)) begin
        miscompares++;
        $display("FAIL full_ready[%0d]: got %b expected %b", i, f_in_ready, i < 2);
      end
      tick();
      vectors++;
      if ({f_imem_we, f_word_count, f_done, f_err_full} !==
          {(i < 2), 9'(i < 2 ? i + 1 : 2), (i >= 1), (i >= 1)}) begin
        miscompares++;
        $display("FAIL full_beat[%0d]: got we=%b wc=%0d done=%b full=%b expected %b %0d %b %b",
                 i, f_imem_we, f_word_count, f_done, f_err_full, i < 2, i < 2 ? i + 1 : 2, i >= 1, i >= 1);
      end
      if (i < 2) begin
        vectors++;
        if ({f_imem_addr, f_imem_wdata} !== {8'hFE + 8'(i), exp}) begin
          miscompares++;
          $display("FAIL full_addr[%0d]: got addr=%h wd=%h expected %h %h",
                   i, f_imem_addr, f_imem_wdata, 8'hFE + 8'(i), exp);
        end
      end
    end
    idle_in();
  endtask

  task automatic test_illegal;
    bit lg;
    logic [19:0] e_mov, e_bad;
    e_mov = ref_encode(MOV, 2, 0, 3, 0, lg);
    e_bad = ref_encode(BAD_OPC, 4, 5, 6, 0, lg);
    do_reset();
    pulse_start();
    drive_beat(MOV, 2, 0, 3, 0, 1'b0);
    tick();
    vectors++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h00, e_mov}) begin
      miscompares++;
      $display("FAIL illegal_first: got we=%b addr=%h wd=%h expected 1 00 %h", imem_we, imem_addr, imem_wdata, e_mov);
    end
    drive_beat(BAD_OPC, 4, 5, 6, 0, 1'b0);
    tick();
`ifdef ENC_CHECK_EN
    vectors++;
    if ({imem_we, word_count, err_illegal} !== {1'b0, 9'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL illegal_skip: got we=%b wc=%0d ill=%b expected 0 1 1", imem_we, word_count, err_illegal);
    end
`else
    vectors++;
    if ({imem_we, imem_addr, imem_wdata, err_illegal} !== {1'b1, 8'h01, e_bad, 1'b0}) begin
      miscompares++;
      $display("FAIL illegal_raw: got we=%b addr=%h wd=%h ill=%b expected 1 01 %h 0",
               imem_we, imem_addr, imem_wdata, err_illegal, e_bad);
    end
`endif
    drive_beat(MOV, 2, 0, 3, 0, 1'b1);
    tick();
    idle_in();
    vectors++;
`ifdef ENC_CHECK_EN
    if ({imem_we, imem_addr, word_count, done, err_illegal} !== {1'b1, 8'h01, 9'd2, 2'b11}) begin
      miscompares++;
      $display("FAIL illegal_last: got we=%b addr=%h wc=%0d done=%b ill=%b expected 1 01 2 1 1",
               imem_we, imem_addr, word_count, done, err_illegal);
    end
`else
    if ({imem_we, imem_addr, word_count, done, err_illegal} !== {1'b1, 8'h02, 9'd3, 2'b10}) begin
      miscompares++;
      $display("FAIL illegal_last: got we=%b addr=%h wc=%0d done=%b ill=%b expected 1 02 3 1 0",
               imem_we, imem_addr, word_count, done, err_illegal);
    end
`endif
    pulse_start();
    vectors++;
    if ({err_illegal, word_count, done} !== {1'b0, 9'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL restart_clear: got ill=%b wc=%0d done=%b expected 0 0 0", err_illegal, word_count, done);
    end
  endtask

  task automatic test_rst_mid;
    do_reset();
    pulse_start();
    drive_beat(MOV, 1, 0, 1, 0, 1'b0);
    @(posedge clk);
    rst = 1'b1;
    idle_in();
    #1;
    vectors++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, busy, done, err_illegal, err_full, word_count}
        !== {1'b0, 1'b0, 8'h00, 20'h0, 4'b0000, 9'd0}) begin
      miscompares++;
      $display("FAIL rst_mid: got rdy=%b we=%b addr=%h wd=%h busy=%b wc=%0d expected all zero",
               in_ready, imem_we, imem_addr, imem_wdata, busy, word_count);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_beat(MOV, 1, 0, 1, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({in_ready, imem_we, busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL rst_idle[%0d]: got rdy=%b we=%b busy=%b expected 0 0 0", i, in_ready, imem_we, busy);
      end
    end
    idle_in();
  endtask

  task automatic test_start_in_run;
    do_reset();
    pulse_start();
    drive_beat(MOV, 1, 0, 2, 0, 1'b0);
    tick();
    idle_in();
    pulse_start();
    vectors++;
    if ({busy, in_ready, imem_we, word_count} !== {3'b110, 9'd1}) begin
      miscompares++;
      $display("FAIL start_ignored: got busy=%b rdy=%b we=%b wc=%0d expected 1 1 0 1",
               busy, in_ready, imem_we, word_count);
    end
    drive_beat(MOV, 1, 0, 2, 0, 1'b1);
    tick();
    idle_in();
    vectors++;
    if ({imem_we, imem_addr, word_count, done} !== {1'b1, 8'h01, 9'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL start_ignored_next: got we=%b addr=%h wc=%0d done=%b expected 1 01 2 1",
               imem_we, imem_addr, word_count, done);
    end
  endtask

  task automatic test_random;
    bit lg;
    logic [19:0] exp;
    int n, k, opc, dst, s1, s0, imm, m_addr, m_wc;
    bit m_ill, v, last;
    do_reset();
    for (int s = 0; s < 8; s++) begin
      pulse_start();
      n = $urandom_range(1, 30);
      k = 0; m_addr = 0; m_wc = 0; m_ill = 1'b0;
      while (k < n) begin
        v = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 9) == 0);
        opc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 18);
        dst = $urandom_range(0, 31); s1 = $urandom_range(0, 31);
        s0 = $urandom_range(0, 31); imm = $urandom_range(0, 255);
        last = (k == n - 1);
        exp = ref_encode(opc, dst, s1, s0, imm, lg);
        if (v) drive_beat(opc, dst, s1, s0, imm, last);
        else in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL rand_ready s%0d k%0d: got %b expected 1", s, k, in_ready);
        end
        tick();
        start = 1'b0;
        if (v) begin
          k++;
          if (lg) begin
            vectors++;
            if ({imem_addr, imem_wdata} !== {8'(m_addr), exp}) begin
              miscompares++;
              $display("FAIL rand_write s%0d k%0d opc=%0d: got addr=%h wd=%h expected %h %h",
                       s, k, opc, imem_addr, imem_wdata, 8'(m_addr), exp);
            end
            m_addr++; m_wc++;
          end else m_ill = 1'b1;
        end
        vectors++;
        if ({imem_we, word_count, err_illegal, done} !== {(v && lg), 9'(m_wc), m_ill, (v && last)}) begin
          miscompares++;
          $display("FAIL rand_state s%0d k%0d: got we=%b wc=%0d ill=%b done=%b expected %b %0d %b %b",
                   s, k, imem_we, word_count, err_illegal, done, v && lg, m_wc, m_ill, v && last);
        end
      end
      idle_in();
      vectors++;
      if ({in_ready, busy, done} !== 3'b001) begin
        miscompares++;
        $display("FAIL rand_end s%0d: got rdy=%b busy=%b done=%b expected 0 0 1", s, in_ready, busy, done);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    test_reset();
    test_single_li();
    test_back_to_back();
    test_full();
    test_illegal();
    test_rst_mid();
    test_start_in_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program-loading encoder that turns field-level instruction descriptions (opcode, dst, src1, src0, 8-bit immediate) into 20-bit instruction words and writes them sequentially into instruction memory. It sits between the host/boot loader and the instruction RAM, so the instruction decoder downstream receives words in exactly its bit layout. Opcode constants come from `def.h`.

## Interface
Parameters:
- START_ADDR, 8'h00, first instruction-memory address written after `start`

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; begins a load session (ignored unless in IDLE or DONE)
- in_valid  in  1  field beat valid
- in_ready  out  1  encoder can accept a beat
- in_last  in  1  beat is the final instruction of the program
- in_opc  in  5  opcode (def.h value)
- in_dst  in  5  destination register
- in_src1  in  5  source register 1
- in_src0  in  5  source register 0
- in_imm  in  8  immediate / jump target
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  8  write address
- imem_wdata  out  20  encoded instruction word
- busy  out  1  session in progress (RUN)
- done  out  1  session finished; held until next `start`
- err_illegal  out  1  sticky: unknown opcode seen this session
- err_full  out  1  sticky: address space exhausted before `in_last`
- word_count  out  9  words written this session (0..256)

## Operation
- States: IDLE -> (start) RUN -> (accepted beat with in_last, or write to 8'hFF) DONE -> (start) RUN.
- `start` in RUN ignored. `start` from IDLE/DONE: addr <= START_ADDR, word_count <= 0, err_* <= 0, done <= 0.
- in_ready = 1 only in RUN; beat accepted when in_valid & in_ready.
- Encoding (unused bit positions forced to 0):
  - INC, DEC, MOV, RL_/UD_/FB_ 90/180/270: {opc, dst, 5'b0, src0}
  - LOAD: {opc, dst, src1, 5'b0}
  - STORE: {opc, 5'b0, src1, src0}
  - LI: {opc, dst, imm, 2'b00}
  - CHECK: {opc, src1, imm, 2'b00} (src1 occupies [14:10])
  - JMP, JNZ, ZNJ: {opc, 7'b0, imm}
- Each written word: imem_addr = current addr, then addr += 1 (8-bit), word_count += 1.
- Full: write to address 8'hFF ends the session (-> DONE); if that beat lacked in_last, err_full <= 1. Addr never wraps within a session.
- Illegal opcode (see Configuration): beat consumed, no write, addr/word_count unchanged, err_illegal <= 1; if it carried in_last, still -> DONE.
- done = 1 in DONE; busy = 1 in RUN.

## Timing
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr START_ADDR, imem_wdata 0, busy 0, done 0, err_illegal 0, err_full 0, word_count 0.
- Latency: beat accepted at edge N -> imem_we/addr/wdata registered, valid during cycle N+1, single-cycle pulse.
- Throughput: one beat per cycle; back-to-back beats give back-to-back writes at consecutive addresses.
- in_ready falls the cycle after the terminating beat (last or addr 8'hFF); done rises the same cycle.
- word_count reflects the write in the same cycle imem_we is high.
- rst mid-session: all outputs to reset values immediately; pending write is dropped.

## Configuration
- ENC_CHECK_EN defined: opcodes not in the list above flagged illegal as specified.
- ENC_CHECK_EN undefined: no check; unknown opcodes encoded raw {opc, dst, src1, src0} and written; err_illegal tied 0.

## Test plan
- start, beat LI dst=3 imm=8'h5A last=1 -> one cycle later imem_we=1, addr=8'h00, wdata={LI,5'd3,8'h5A,2'b00}; done=1, word_count=1.
- start, 3 back-to-back beats (INC dst=1 src0=2; STORE src1=4 src0=5; JNZ imm=8'h10 last) -> writes at 0,1,2 on consecutive cycles, wdata {INC,5'd1,5'd0,5'd2}, {STORE,5'd0,5'd4,5'd5}, {JNZ,7'b0,8'h10}.
- START_ADDR=8'hFE, 3 beats without last -> writes at FE, FF; third beat not accepted, done=1, err_full=1, word_count=2.
- ENC_CHECK_EN, unused opcode beat between two MOVs -> two writes at addresses 0,1, err_illegal=1; without macro -> three writes.
- rst asserted the cycle after a beat is accepted -> no imem_we pulse, all outputs at reset values, in_ready=0 until next start.
- start pulsed during RUN with in_valid low -> ignored; addr and word_count unchanged.
